// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI types, response codes and FSM state encodings for the memory responder.
package axi_mem_responder_pkg;

  localparam int AXI_ID_W = 4;

  typedef logic [AXI_ID_W-1:0] axi_id_t;
  typedef logic [1:0]          axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_resp_mem.sv
// Word-addressed backing store: one byte-enable write port, one read port with
// registered output. A read and a write to the same word in one cycle return the old value.
module axi_resp_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write into the array.
  // NOTE: the array has no reset so it maps onto RAM; only the output register below is reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Registered read port; holds its value while re is low so a stalled beat stays stable.
  // NOTE: non-blocking assignments here and above are what make a same-cycle read see the old word.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI slave memory responder: independent write (AW/W/B) and read (AR/R) FSMs
// sharing one word-addressed memory, one outstanding transaction per direction.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [3:0]          aw_len,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [3:0]          ar_len,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic [ID_W-1:0]     r_id,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                r_last,
  output logic                r_valid,
  input  logic                r_ready
);

  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam int IDX_W      = ADDR_W - BYTE_SHIFT;
  localparam int MEM_AW     = $clog2(DEPTH);

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic out_of_range(input idx_t idx);
    return {1'b0, idx} >= (IDX_W + 1)'(DEPTH);
  endfunction

  logic unused_ok;
  assign unused_ok = ^{aw_addr[BYTE_SHIFT-1:0], ar_addr[BYTE_SHIFT-1:0]};

  // Keep both address channels closed for the first cycle after reset.
  logic ready_en;
  always_ff @(posedge clk) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // ---------------- write path ----------------
  w_state_t    w_state, w_state_nxt;
  idx_t        w_idx;
  logic [3:0]  w_len, w_cnt;
  logic        w_dec, w_oob, w_final, w_end, aw_hs, w_hs;

  assign w_oob   = out_of_range(w_idx);
  assign w_final = (w_cnt == w_len);
  assign w_end   = w_last || w_final;
  assign aw_hs   = aw_valid && aw_ready;
  assign w_hs    = w_valid && w_ready;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // Write FSM next state and channel handshake outputs.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = w_state;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_ready = ready_en;
        if (aw_valid && ready_en) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w_valid && w_end) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (b_ready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst bookkeeping and response; DECERR outranks SLVERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_id   <= '0;
      b_resp <= RESP_OKAY;
      w_idx  <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_dec  <= 1'b0;
    end else if (aw_hs) begin
      b_id   <= aw_id;
      w_idx  <= aw_addr[ADDR_W-1:BYTE_SHIFT];
      w_len  <= aw_len;
      w_cnt  <= '0;
      w_dec  <= 1'b0;
    end else if (w_hs) begin
      w_idx  <= w_idx + 1'b1;
      w_cnt  <= w_cnt + 1'b1;
      w_dec  <= w_dec | w_oob;
      if (w_end) begin
        if (w_dec || w_oob)      b_resp <= RESP_DECERR;
        else if (w_last != w_final) b_resp <= RESP_SLVERR;
        else                     b_resp <= RESP_OKAY;
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t    r_state, r_state_nxt;
  idx_t        r_idx, r_idx_nxt, ar_idx;
  logic [3:0]  r_len, r_cnt;
  logic        r_oob, ar_hs, r_advance, mem_re;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign ar_idx    = ar_addr[ADDR_W-1:BYTE_SHIFT];
  assign r_idx_nxt = r_idx + 1'b1;
  assign ar_hs     = ar_valid && ar_ready;
  assign r_advance = r_valid && r_ready && !r_last;
  assign mem_re    = ar_hs || r_advance;
  assign mem_raddr = ar_hs ? ar_idx[MEM_AW-1:0] : r_idx_nxt[MEM_AW-1:0];
  assign r_data    = r_oob ? '0 : mem_rdata;
  assign r_resp    = r_oob ? RESP_DECERR : RESP_OKAY;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    r_state_nxt = r_state;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    r_last      = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ar_ready = ready_en;
        if (ar_valid && ready_en) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        r_last  = (r_cnt == r_len);
        if (r_ready && r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst bookkeeping; r_oob tracks whether the beat now on R is out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id  <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_oob <= 1'b0;
    end else if (ar_hs) begin
      r_id  <= ar_id;
      r_idx <= ar_idx;
      r_len <= ar_len;
      r_cnt <= '0;
      r_oob <= out_of_range(ar_idx);
    end else if (r_advance) begin
      r_idx <= r_idx_nxt;
      r_cnt <= r_cnt + 1'b1;
      r_oob <= out_of_range(r_idx_nxt);
    end
  end

  axi_resp_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs && !w_oob),
    .waddr (w_idx[MEM_AW-1:0]),
    .wdata (w_data),
    .wstrb (w_strb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: reset state, single and burst transfers,
// strobes, burst-length errors, decode errors and reset in the middle of a read.
module tb_axi_mem_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic        clk, rst;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [3:0]  aw_len, ar_len, w_strb;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_last, r_valid, r_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rdat [16];
  logic [1:0]  rresp [16];
  logic        rlast [16];
  logic [3:0]  rid [16];
  logic [1:0]  bresp;
  logic [3:0]  bid;
  int          blat;
  int          wlat0;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Full write burst: nbeats beats from wbuf/sbuf, w_last on the final one if with_last,
  // B held off for b_delay cycles while its payload is checked for stability.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats, input bit with_last, input int b_delay,
                           output logic [1:0] resp, output logic [3:0] bid_o, output int b_lat);
    int n;
    @(negedge clk);
    aw_id = id; aw_addr = addr; aw_len = len; aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    if (!aw_ready) begin checks++; errors++; $display("FAIL aw_timeout: aw_ready got 0, expected 1"); end
    @(posedge clk); @(negedge clk);
    aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      w_data = wbuf[i]; w_strb = sbuf[i]; w_last = with_last && (i == nbeats - 1); w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      if (i == 0) wlat0 = n;
      if (!w_ready) begin checks++; errors++; $display("FAIL w_timeout: w_ready got 0, expected 1"); end
      @(posedge clk); @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_lat = 0;
    while (!b_valid && b_lat < 50) begin @(negedge clk); b_lat++; end
    resp = b_resp; bid_o = b_id;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      checks++;
      if ({b_valid, b_resp, b_id} !== {1'b1, resp, bid_o}) begin
        errors++;
        $display("FAIL b_stable: got valid=%b resp=%b id=%h, expected valid=1 resp=%b id=%h",
                 b_valid, b_resp, b_id, resp, bid_o);
      end
    end
    b_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_ready = 1'b0;
  endtask

  // Full read burst of len+1 beats into rdat/rresp/rlast/rid; with toggle, r_ready
  // alternates 0/1 and every stalled beat is checked unchanged on the next cycle.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input bit toggle);
    int n, cyc, beat;
    bit have_prev;
    logic [38:0] prev;
    @(negedge clk);
    ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!ar_ready) begin checks++; errors++; $display("FAIL ar_timeout: ar_ready got 0, expected 1"); end
    @(posedge clk); @(negedge clk);
    ar_valid = 1'b0;
    beat = 0; cyc = 0; have_prev = 1'b0;
    while (beat <= int'(len) && cyc < 100) begin
      if (have_prev) begin
        checks++;
        if ({r_valid, r_data, r_resp, r_last, r_id} !== {1'b1, prev}) begin
          errors++;
          $display("FAIL r_stable: got data=%h resp=%b last=%b, expected data=%h resp=%b last=%b",
                   r_data, r_resp, r_last, prev[38:7], prev[6:5], prev[4]);
        end
        have_prev = 1'b0;
      end
      r_ready = toggle ? cyc[0] : 1'b1;
      if (r_valid) begin
        if (r_ready) begin
          rdat[beat] = r_data; rresp[beat] = r_resp; rlast[beat] = r_last; rid[beat] = r_id;
          beat++;
        end else begin
          prev = {r_data, r_resp, r_last, r_id};
          have_prev = 1'b1;
        end
      end
      cyc++;
      @(posedge clk); @(negedge clk);
    end
    r_ready = 1'b0;
    if (beat <= int'(len)) begin
      checks++; errors++;
      $display("FAIL r_timeout: got %0d beats, expected %0d", beat, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last});
    end
    checks++;
    if ({b_id, b_resp, r_id, r_data, r_resp} !== 44'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h, expected 0", {b_id, b_resp, r_id, r_data, r_resp});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({aw_ready, ar_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready_early: got %b, expected 00", {aw_ready, ar_ready});
    end
    @(negedge clk);
    checks++;
    if ({aw_ready, ar_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready_rise: got %b, expected 11", {aw_ready, ar_ready});
    end
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_write(4'h3, 32'h10, 4'd0, 1, 1'b1, 2, bresp, bid, blat);
    checks++;
    if ({bresp, bid} !== {OKAY, 4'h3}) begin
      errors++; $display("FAIL single_b: got resp=%b id=%h, expected resp=00 id=3", bresp, bid);
    end
    checks++;
    if ({wlat0, blat} != {32'd0, 32'd0}) begin
      errors++; $display("FAIL single_latency: got w=%0d b=%0d, expected 0 0", wlat0, blat);
    end
    axi_read(4'h5, 32'h10, 4'd0, 1'b0);
    checks++;
    if ({rdat[0], rresp[0], rlast[0], rid[0]} !== {32'hDEADBEEF, OKAY, 1'b1, 4'h5}) begin
      errors++;
      $display("FAIL single_r: got data=%h resp=%b last=%b id=%h, expected deadbeef 00 1 5",
               rdat[0], rresp[0], rlast[0], rid[0]);
    end
    checks++;
    if (ar_ready !== 1'b1) begin errors++; $display("FAIL ar_ready_after_last: got %b, expected 1", ar_ready); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(4'hA, 32'h100, 4'd3, 4, 1'b1, 0, bresp, bid, blat);
    checks++;
    if ({bresp, bid, blat} !== {OKAY, 4'hA, 32'd0}) begin
      errors++; $display("FAIL burst_b: got resp=%b id=%h lat=%0d, expected 00 a 0", bresp, bid, blat);
    end
    axi_read(4'h7, 32'h100, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rdat[i], rresp[i], rlast[i], rid[i]} !== {32'(i + 1), OKAY, (i == 3), 4'h7}) begin
        errors++;
        $display("FAIL burst_beat%0d: got data=%h resp=%b last=%b id=%h, expected data=%h 00 %b 7",
                 i, rdat[i], rresp[i], rlast[i], rid[i], i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    axi_write(4'h1, 32'h200, 4'd0, 1, 1'b1, 0, bresp, bid, blat);
    wbuf[0] = 32'h00000000; sbuf[0] = 4'h5;
    axi_write(4'h1, 32'h200, 4'd0, 1, 1'b1, 0, bresp, bid, blat);
    axi_read(4'h1, 32'h200, 4'd0, 1'b0);
    checks++;
    if (rdat[0] !== 32'hFF00FF00) begin
      errors++; $display("FAIL strobe: got %h, expected ff00ff00", rdat[0]);
    end
  endtask

  task automatic test_len_errors();
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hAAAA0000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(4'h2, 32'h300, 4'd3, 4, 1'b1, 0, bresp, bid, blat);
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    axi_write(4'h4, 32'h300, 4'd3, 2, 1'b1, 0, bresp, bid, blat);
    checks++;
    if ({bresp, bid, w_ready} !== {SLVERR, 4'h4, 1'b0}) begin
      errors++; $display("FAIL early_last: got resp=%b id=%h w_ready=%b, expected 10 4 0", bresp, bid, w_ready);
    end
    axi_read(4'h2, 32'h300, 4'd3, 1'b0);
    checks++;
    if ({rdat[0], rdat[1], rdat[2], rdat[3]} !== {32'h11, 32'h22, 32'hAAAA0002, 32'hAAAA0003}) begin
      errors++;
      $display("FAIL early_last_data: got %h %h %h %h, expected 11 22 aaaa0002 aaaa0003",
               rdat[0], rdat[1], rdat[2], rdat[3]);
    end
    wbuf[0] = 32'h33; wbuf[1] = 32'h44;
    axi_write(4'h6, 32'h400, 4'd1, 2, 1'b0, 0, bresp, bid, blat);
    checks++;
    if (bresp !== SLVERR) begin errors++; $display("FAIL missing_last: got %b, expected 10", bresp); end
    axi_read(4'h6, 32'h400, 4'd1, 1'b0);
    checks++;
    if ({rdat[0], rdat[1], rlast[0], rlast[1]} !== {32'h33, 32'h44, 1'b0, 1'b1}) begin
      errors++; $display("FAIL missing_last_data: got %h %h, expected 33 44", rdat[0], rdat[1]);
    end
  endtask

  task automatic test_decerr();
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    axi_write(4'h1, 32'h0, 4'd0, 1, 1'b1, 0, bresp, bid, blat);
    wbuf[0] = 32'h00000BAD;
    axi_write(4'h8, 32'h1000, 4'd0, 1, 1'b1, 0, bresp, bid, blat);
    checks++;
    if ({bresp, bid} !== {DECERR, 4'h8}) begin
      errors++; $display("FAIL decerr_write: got resp=%b id=%h, expected 11 8", bresp, bid);
    end
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    axi_write(4'h9, 32'hFFC, 4'd1, 2, 1'b1, 0, bresp, bid, blat);
    checks++;
    if (bresp !== DECERR) begin errors++; $display("FAIL decerr_span_write: got %b, expected 11", bresp); end
    axi_write(4'h9, 32'h1000, 4'd1, 1, 1'b1, 0, bresp, bid, blat);
    checks++;
    if (bresp !== DECERR) begin errors++; $display("FAIL decerr_over_slverr: got %b, expected 11", bresp); end
    axi_read(4'hC, 32'hFFC, 4'd1, 1'b0);
    checks++;
    if ({rdat[0], rresp[0], rlast[0]} !== {32'h55, OKAY, 1'b0}) begin
      errors++; $display("FAIL decerr_beat1: got %h %b %b, expected 55 00 0", rdat[0], rresp[0], rlast[0]);
    end
    checks++;
    if ({rdat[1], rresp[1], rlast[1], rid[1]} !== {32'h0, DECERR, 1'b1, 4'hC}) begin
      errors++;
      $display("FAIL decerr_beat2: got %h %b %b %h, expected 0 11 1 c", rdat[1], rresp[1], rlast[1], rid[1]);
    end
    axi_read(4'h0, 32'h0, 4'd0, 1'b0);
    checks++;
    if (rdat[0] !== 32'h12345678) begin
      errors++; $display("FAIL decerr_no_alias: got %h, expected 12345678", rdat[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    @(negedge clk);
    ar_id = 4'h9; ar_addr = 32'h100; ar_len = 4'd3; ar_valid = 1'b1; r_ready = 1'b1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    ar_valid = 1'b0;
    checks++;
    if ({r_valid, r_data} !== {1'b1, 32'd1}) begin
      errors++; $display("FAIL rst_read_beat1: got valid=%b data=%h, expected 1 1", r_valid, r_data);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({r_valid, r_data, r_last} !== {1'b1, 32'd2, 1'b0}) begin
      errors++; $display("FAIL rst_read_beat2: got valid=%b data=%h last=%b, expected 1 2 0", r_valid, r_data, r_last);
    end
    rst = 1'b1; r_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({r_valid, ar_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_abort: got r_valid=%b ar_ready=%b, expected 0 0", r_valid, ar_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ar_ready !== 1'b0) begin errors++; $display("FAIL rst_ar_ready_early: got %b, expected 0", ar_ready); end
    @(negedge clk);
    checks++;
    if (ar_ready !== 1'b1) begin errors++; $display("FAIL rst_ar_ready_rise: got %b, expected 1", ar_ready); end
    axi_read(4'h2, 32'h100, 4'd0, 1'b0);
    checks++;
    if ({rdat[0], rid[0], rlast[0]} !== {32'd1, 4'h2, 1'b1}) begin
      errors++; $display("FAIL rst_recover: got %h id=%h, expected 1 id=2", rdat[0], rid[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0;
    wlat0 = 0;
    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_len_errors();
    test_decerr();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
